dllp_tx_arbiter: RTL and testbench



---
 rtl/pcie_datalink_pkg.sv | 18 +
 rtl/dllp_tx_arb_pick.sv | 29 ++
 rtl/dllp_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_dllp_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_datalink_pkg.sv
// Shared types and constants for the datalink transmit path.
package pcie_datalink_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_SEND
  } tx_arb_state_e;

  // Grant bit indices into the one-hot grant vector.
  localparam int unsigned ArbAck = 0;
  localparam int unsigned ArbFc  = 1;
  localparam int unsigned ArbTlp = 2;

  localparam logic [2:0] GntAck = 3'b001;
  localparam logic [2:0] GntFc  = 3'b010;
  localparam logic [2:0] GntTlp = 3'b100;

endpackage

// File: rtl/dllp_tx_arb_pick.sv
// Combinational priority picker: DLLPs over TLPs, unless the TLP has waited
// through MAX_DLLP_BURST DLLP grants, in which case the TLP is forced.
module dllp_tx_arb_pick
  import pcie_datalink_pkg::*;
#(
  parameter int unsigned MAX_DLLP_BURST = 4
) (
  input  logic [2:0] valids_i,
  input  logic [3:0] burst_cnt_i,
  output logic [2:0] grant_o
);

  localparam logic [3:0] MaxBurst = 4'(MAX_DLLP_BURST);

  // Starvation override first, then fixed ack > fc > tlp order.
  always_comb begin
    grant_o = '0;
    if (valids_i[ArbTlp] && (burst_cnt_i == MaxBurst)) begin
      grant_o = GntTlp;
    end else if (valids_i[ArbAck]) begin
      grant_o = GntAck;
    end else if (valids_i[ArbFc]) begin
      grant_o = GntFc;
    end else if (valids_i[ArbTlp]) begin
      grant_o = GntTlp;
    end
  end

endmodule

// File: rtl/dllp_tx_arbiter.sv
// Packet-atomic arbiter sharing the datalink-to-physical AXIS bus between the
// Ack/Nak DLLP generator, the UpdateFC DLLP generator and the TLP stream.
module dllp_tx_arbiter
  import pcie_datalink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH     = 4,
  parameter int unsigned MAX_DLLP_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  phy_link_up_i,

  input  logic [DATA_WIDTH-1:0] s_axis_ack_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_ack_tkeep,
  input  logic                  s_axis_ack_tvalid,
  input  logic                  s_axis_ack_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_ack_tuser,
  output logic                  s_axis_ack_tready,

  input  logic [DATA_WIDTH-1:0] s_axis_fc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_fc_tkeep,
  input  logic                  s_axis_fc_tvalid,
  input  logic                  s_axis_fc_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_fc_tuser,
  output logic                  s_axis_fc_tready,

  input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep,
  input  logic                  s_axis_tlp_tvalid,
  input  logic                  s_axis_tlp_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser,
  output logic                  s_axis_tlp_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,

  output logic [2:0]            grant_o,
  output logic                  busy_o
);

  localparam logic [3:0] MaxBurst = 4'(MAX_DLLP_BURST);

  tx_arb_state_e state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic [2:0]    valids;
  logic [2:0]    pick_grant;

  assign valids = {s_axis_tlp_tvalid, s_axis_fc_tvalid, s_axis_ack_tvalid};

  dllp_tx_arb_pick #(
    .MAX_DLLP_BURST(MAX_DLLP_BURST)
  ) u_pick (
    .valids_i    (valids),
    .burst_cnt_i (burst_cnt_q),
    .grant_o     (pick_grant)
  );

  // Next state: grant in IDLE when the link is up, release on the last beat.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (phy_link_up_i && (|valids)) begin
          state_d = ARB_SEND;
          grant_d = pick_grant;
          // Count DLLP grants only while a TLP is actually waiting.
          if (pick_grant[ArbTlp] || !valids[ArbTlp]) begin
            burst_cnt_d = '0;
          end else if (burst_cnt_q < MaxBurst) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end
      end
      ARB_SEND: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output mux: the granted source drives the bus; everyone else is held off.
  always_comb begin
    m_axis_tdata      = '0;
    m_axis_tkeep      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    m_axis_tuser      = '0;
    s_axis_ack_tready = 1'b0;
    s_axis_fc_tready  = 1'b0;
    s_axis_tlp_tready = 1'b0;
    if (state_q == ARB_SEND) begin
      unique case (grant_q)
        GntAck: begin
          m_axis_tdata      = s_axis_ack_tdata;
          m_axis_tkeep      = s_axis_ack_tkeep;
          m_axis_tvalid     = s_axis_ack_tvalid;
          m_axis_tlast      = s_axis_ack_tlast;
          m_axis_tuser      = s_axis_ack_tuser;
          s_axis_ack_tready = m_axis_tready;
        end
        GntFc: begin
          m_axis_tdata      = s_axis_fc_tdata;
          m_axis_tkeep      = s_axis_fc_tkeep;
          m_axis_tvalid     = s_axis_fc_tvalid;
          m_axis_tlast      = s_axis_fc_tlast;
          m_axis_tuser      = s_axis_fc_tuser;
          s_axis_fc_tready  = m_axis_tready;
        end
        GntTlp: begin
          m_axis_tdata      = s_axis_tlp_tdata;
          m_axis_tkeep      = s_axis_tlp_tkeep;
          m_axis_tvalid     = s_axis_tlp_tvalid;
          m_axis_tlast      = s_axis_tlp_tlast;
          m_axis_tuser      = s_axis_tlp_tuser;
          s_axis_tlp_tready = m_axis_tready;
        end
        default: ;
      endcase
    end
  end

  // State, grant and burst counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ARB_SEND);

endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// Directed bench for dllp_tx_arbiter: priority, starvation bound, back-pressure,
// link-down and mid-packet reset scenarios.
module tb_dllp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        link;
  logic [31:0] ack_tdata, fc_tdata, tlp_tdata, m_tdata;
  logic [3:0]  ack_tkeep, fc_tkeep, tlp_tkeep, m_tkeep;
  logic [3:0]  ack_tuser, fc_tuser, tlp_tuser, m_tuser;
  logic        ack_tvalid, fc_tvalid, tlp_tvalid, m_tvalid;
  logic        ack_tlast, fc_tlast, tlp_tlast, m_tlast;
  logic        ack_tready, fc_tready, tlp_tready, m_tready;
  logic [2:0]  grant;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int beat;
  int cyc;

  always #5 clk = ~clk;

  dllp_tx_arbiter #(
    .DATA_WIDTH     (32),
    .KEEP_WIDTH     (4),
    .USER_WIDTH     (4),
    .MAX_DLLP_BURST (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .phy_link_up_i     (link),
    .s_axis_ack_tdata  (ack_tdata),
    .s_axis_ack_tkeep  (ack_tkeep),
    .s_axis_ack_tvalid (ack_tvalid),
    .s_axis_ack_tlast  (ack_tlast),
    .s_axis_ack_tuser  (ack_tuser),
    .s_axis_ack_tready (ack_tready),
    .s_axis_fc_tdata   (fc_tdata),
    .s_axis_fc_tkeep   (fc_tkeep),
    .s_axis_fc_tvalid  (fc_tvalid),
    .s_axis_fc_tlast   (fc_tlast),
    .s_axis_fc_tuser   (fc_tuser),
    .s_axis_fc_tready  (fc_tready),
    .s_axis_tlp_tdata  (tlp_tdata),
    .s_axis_tlp_tkeep  (tlp_tkeep),
    .s_axis_tlp_tvalid (tlp_tvalid),
    .s_axis_tlp_tlast  (tlp_tlast),
    .s_axis_tlp_tuser  (tlp_tuser),
    .s_axis_tlp_tready (tlp_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tkeep      (m_tkeep),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tlast      (m_tlast),
    .m_axis_tuser      (m_tuser),
    .m_axis_tready     (m_tready),
    .grant_o           (grant),
    .busy_o            (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_treadys"}, {ack_tready, fc_tready, tlp_tready}, 0);
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] g, input logic [31:0] d,
                          input logic l);
    chk({tag, "_tvalid"}, m_tvalid, 1);
    chk({tag, "_grant"}, grant, g);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_tdata"}, m_tdata, d);
    chk({tag, "_tlast"}, m_tlast, l);
  endtask

  task automatic drv_ack(input logic v, input logic [31:0] d, input logic l);
    ack_tvalid = v; ack_tdata = d; ack_tlast = l;
  endtask

  task automatic drv_fc(input logic v, input logic [31:0] d, input logic l);
    fc_tvalid = v; fc_tdata = d; fc_tlast = l;
  endtask

  task automatic drv_tlp(input logic v, input logic [31:0] d, input logic l);
    tlp_tvalid = v; tlp_tdata = d; tlp_tlast = l;
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; link = 1'b0; m_tready = 1'b0;
    ack_tkeep = 4'h3; ack_tuser = 4'h1;
    fc_tkeep  = 4'hF; fc_tuser  = 4'h2;
    tlp_tkeep = 4'h7; tlp_tuser = 4'h9;
    drv_ack(0, 0, 0); drv_fc(0, 0, 0); drv_tlp(0, 0, 0);

    // 1. Reset and idle.
    step(); step(); settle();
    chk_idle("t1_rst");
    chk("t1_rst_tlast", m_tlast, 0);
    chk("t1_rst_tdata", {m_tdata, m_tkeep, m_tuser}, 0);
    rst = 1'b0; link = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); settle();
      chk_idle($sformatf("t1_idle%0d", i));
    end

    // 2. Priority ack > fc > tlp with one bubble between packets.
    drv_ack(1, 32'hA000_0000, 1);
    drv_fc(1, 32'hF000_0000, 0);
    drv_tlp(1, 32'h7000_0000, 0);
    m_tready = 1'b1;
    settle();
    chk_idle("t2_decide");
    step(); settle();
    chk_beat("t2_ack", 3'b001, 32'hA000_0000, 1);
    chk("t2_ack_keep", m_tkeep, 4'h3);
    chk("t2_ack_user", m_tuser, 4'h1);
    chk("t2_ack_treadys", {ack_tready, fc_tready, tlp_tready}, 3'b100);
    step(); drv_ack(0, 0, 0); settle();
    chk_idle("t2_bubble1");
    step(); settle();
    chk_beat("t2_fc0", 3'b010, 32'hF000_0000, 0);
    chk("t2_fc_treadys", {ack_tready, fc_tready, tlp_tready}, 3'b010);
    step(); drv_fc(1, 32'hF000_0001, 1); settle();
    chk_beat("t2_fc1", 3'b010, 32'hF000_0001, 1);
    chk("t2_fc_user", m_tuser, 4'h2);
    step(); drv_fc(0, 0, 0); settle();
    chk_idle("t2_bubble2");
    step();
    for (int b = 0; b < 4; b++) begin
      drv_tlp(1, 32'h7000_0000 + b, b == 3);
      settle();
      chk_beat($sformatf("t2_tlp%0d", b), 3'b100, 32'h7000_0000 + b, b == 3);
      step();
    end
    drv_tlp(0, 0, 0); settle();
    chk_idle("t2_done");
    chk("t2_burst", dut.burst_cnt_q, 0);

    // 3. Starvation bound: four DLLPs, then the waiting TLP is forced.
    drv_ack(1, 32'hA000_0005, 1);
    drv_fc(1, 32'hF000_0005, 1);
    drv_tlp(1, 32'h7000_0009, 1);
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      chk_beat($sformatf("t3_ack%0d", i), 3'b001, 32'hA000_0005, 1);
      step(); settle();
      chk_idle($sformatf("t3_gap%0d", i));
      chk($sformatf("t3_burst%0d", i), dut.burst_cnt_q, i + 1);
    end
    step(); settle();
    chk_beat("t3_tlp", 3'b100, 32'h7000_0009, 1);
    chk("t3_burst_clr", dut.burst_cnt_q, 0);
    step(); drv_ack(0, 0, 0); drv_fc(0, 0, 0); drv_tlp(0, 0, 0); settle();
    chk_idle("t3_done");

    // 4. 6-beat TLP under toggling back-pressure; ack arrives mid-packet.
    drv_tlp(1, 32'h7100_0000, 0);
    step();
    beat = 0; cyc = 0;
    while (beat < 6 && cyc < 40) begin
      m_tready = (cyc % 2 == 0);
      drv_tlp(1, 32'h7100_0000 + beat, beat == 5);
      if (beat >= 2) drv_ack(1, 32'hA000_0007, 1);
      settle();
      chk_beat($sformatf("t4_c%0d", cyc), 3'b100, 32'h7100_0000 + beat, beat == 5);
      chk($sformatf("t4_ack_rdy%0d", cyc), ack_tready, 0);
      chk($sformatf("t4_tlp_rdy%0d", cyc), tlp_tready, m_tready);
      step();
      if (m_tready) beat++;
      cyc++;
    end
    chk("t4_beats", beat, 6);
    drv_tlp(0, 0, 0); m_tready = 1'b1; settle();
    chk_idle("t4_bubble");
    step(); settle();
    chk_beat("t4_ack", 3'b001, 32'hA000_0007, 1);
    step(); drv_ack(0, 0, 0); settle();
    chk_idle("t4_done");

    // 5. Link drops mid-TLP: packet completes, fc waits for link return.
    drv_tlp(1, 32'h7200_0000, 0);
    step();
    for (int b = 0; b < 5; b++) begin
      drv_tlp(1, 32'h7200_0000 + b, b == 4);
      if (b >= 1) drv_fc(1, 32'hF000_0009, 1);
      if (b == 2) link = 1'b0;
      settle();
      chk_beat($sformatf("t5_tlp%0d", b), 3'b100, 32'h7200_0000 + b, b == 4);
      step();
    end
    drv_tlp(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_idle($sformatf("t5_down%0d", i));
      step();
    end
    link = 1'b1; settle();
    chk_idle("t5_up");
    step(); settle();
    chk_beat("t5_fc", 3'b010, 32'hF000_0009, 1);
    step(); drv_fc(0, 0, 0); settle();
    chk_idle("t5_done");

    // 6. Reset in the middle of an fc packet.
    drv_fc(1, 32'hF000_00A0, 0);
    step(); settle();
    chk_beat("t6_fc0", 3'b010, 32'hF000_00A0, 0);
    step(); drv_fc(1, 32'hF000_00A1, 0); rst = 1'b1; settle();
    chk_beat("t6_fc1", 3'b010, 32'hF000_00A1, 0);
    step(); rst = 1'b0; drv_fc(0, 0, 0); drv_ack(1, 32'hA000_00AB, 1); settle();
    chk_idle("t6_rst");
    step(); settle();
    chk_beat("t6_ack", 3'b001, 32'hA000_00AB, 1);
    step(); drv_ack(0, 0, 0); settle();
    chk_idle("t6_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
